// File: rtl/calc_operand_stage.sv
// rtl/calc_operand_stage.sv - operand preparation stage: sign/magnitude split, range checks, tagging
module calc_operand_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic [6:0]       out_mag_a,
  output logic [6:0]       out_mag_b,
  output logic             out_sign_a,
  output logic             out_sign_b,
  output logic             out_neg,
  output logic             out_swap,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] tag_cnt;

  logic [7:0] mag_a;
  logic [7:0] mag_b;
  logic       bad_range;
  logic       mul_direct;
  logic       mul_swapped;
  logic       chk_err;
  logic       chk_swap;

  // 0x80 negates to itself, so its 8-bit magnitude stays 0x80 and fails every range test
  always_comb begin
    mag_a       = a_q[7] ? (~a_q + 8'd1) : a_q;
    mag_b       = b_q[7] ? (~b_q + 8'd1) : b_q;
    bad_range   = (a_q == 8'h80) || (b_q == 8'h80);
    mul_direct  = (mag_a <= 8'd15) && (mag_b <= 8'd7);
    mul_swapped = (mag_b <= 8'd15) && (mag_a <= 8'd7);
    chk_err     = bad_range
                  || ((op_q == OP_DIV) && (b_q == 8'd0))
                  || ((op_q == OP_MUL) && !mul_direct && !mul_swapped);
    chk_swap    = !chk_err && (op_q == OP_MUL) && !mul_direct;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      tag_cnt    <= '0;
      out_valid  <= 1'b0;
      out_op     <= '0;
      out_mag_a  <= '0;
      out_mag_b  <= '0;
      out_sign_a <= 1'b0;
      out_sign_b <= 1'b0;
      out_neg    <= 1'b0;
      out_swap   <= 1'b0;
      out_err    <= 1'b0;
      out_tag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            a_q     <= in_a;
            b_q     <= in_b;
            tag_q   <= tag_cnt;
            tag_cnt <= tag_cnt + 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          out_op     <= op_q;
          out_tag    <= tag_q;
          out_err    <= chk_err;
          out_swap   <= chk_swap;
          out_sign_a <= chk_swap ? b_q[7] : a_q[7];
          out_sign_b <= chk_swap ? a_q[7] : b_q[7];
          out_neg    <= !chk_err && op_q[1] && (a_q[7] ^ b_q[7]);
          out_mag_a  <= chk_err ? 7'd0 : (chk_swap ? mag_b[6:0] : mag_a[6:0]);
          out_mag_b  <= chk_err ? 7'd0 : (chk_swap ? mag_a[6:0] : mag_b[6:0]);
          state      <= ISSUE;
        end
        ISSUE: begin
          // valid rises one edge after the fields land; out_ready only counts once valid is up
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_operand_stage.sv
// tb/tb_calc_operand_stage.sv - directed and random checks of calc_operand_stage against a reference model
module tb_calc_operand_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_op;
  logic [6:0] out_mag_a;
  logic [6:0] out_mag_b;
  logic       out_sign_a;
  logic       out_sign_b;
  logic       out_neg;
  logic       out_swap;
  logic       out_err;
  logic [3:0] out_tag;

  int checks = 0;
  int passes = 0;
  int exp_tag = 0;

  typedef struct packed {
    logic       err;
    logic       swap;
    logic       neg;
    logic       sa;
    logic       sb;
    logic [6:0] ma;
    logic [6:0] mb;
  } exp_t;

  calc_operand_stage #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_mag_a(out_mag_a), .out_mag_b(out_mag_b),
    .out_sign_a(out_sign_a), .out_sign_b(out_sign_b),
    .out_neg(out_neg), .out_swap(out_swap), .out_err(out_err), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int va, vb, ma, mb;
    bit err, swp;
    va  = int'($signed(a));
    vb  = int'($signed(b));
    ma  = (va < 0) ? -va : va;
    mb  = (vb < 0) ? -vb : vb;
    err = (va == -128) || (vb == -128);
    swp = 1'b0;
    if (op == 2'd3 && vb == 0) err = 1'b1;
    if (op == 2'd2 && !err) begin
      if (ma <= 15 && mb <= 7) swp = 1'b0;
      else if (mb <= 15 && ma <= 7) swp = 1'b1;
      else err = 1'b1;
    end
    e.err  = err;
    e.swap = swp;
    e.sa   = swp ? b[7] : a[7];
    e.sb   = swp ? a[7] : b[7];
    e.neg  = (!err && op >= 2'd2) ? (a[7] ^ b[7]) : 1'b0;
    e.ma   = err ? 7'd0 : 7'(swp ? mb : ma);
    e.mb   = err ? 7'd0 : 7'(swp ? ma : mb);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_fields(input string tag, input logic [1:0] op, input exp_t e);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " op"},    32'(out_op), 32'(op));
    check({tag, " mag_a"}, 32'(out_mag_a), 32'(e.ma));
    check({tag, " mag_b"}, 32'(out_mag_b), 32'(e.mb));
    check({tag, " sign_a"}, 32'(out_sign_a), 32'(e.sa));
    check({tag, " sign_b"}, 32'(out_sign_b), 32'(e.sb));
    check({tag, " neg"},   32'(out_neg), 32'(e.neg));
    check({tag, " swap"},  32'(out_swap), 32'(e.swap));
    check({tag, " err"},   32'(out_err), 32'(e.err));
    check({tag, " tag"},   32'(out_tag), 32'(exp_tag));
  endtask

  // Starts just after a rising edge; ends just after the edge that returns the block to idle.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int hold);
    exp_t e;
    e = model(op, a, b);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = (hold == 0);
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'($urandom);
    in_op    = 2'($urandom);
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    @(negedge clk);
    check({tag, " busy in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " early valid1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, " early valid2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_fields(tag, op, e);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom);
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      @(negedge clk);
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      check_fields({tag, " hold"}, op, e);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " back idle"}, 32'(in_ready), 32'd1);
    check({tag, " valid drop"}, 32'(out_valid), 32'd0);
    exp_tag = (exp_tag + 1) % 16;
  endtask

  function automatic logic [7:0] rand_operand();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 8'h80;
    if (r <= 2) return 8'($urandom);
    return 8'(int'($urandom_range(0, 40)) - 20);
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    out_ready = 1'b0;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_tag",   32'(out_tag), 32'd0);
    check("reset out_err",   32'(out_err), 32'd0);
    check("reset mag_a",     32'(out_mag_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    do_req("mul_neg5_6", 2'd2, 8'hFB, 8'd6, 0);
    do_req("mul_3_12",   2'd2, 8'd3, 8'd12, 0);
    do_req("mul_9_9",    2'd2, 8'd9, 8'd9, 0);
    do_req("div_b0",     2'd3, 8'd7, 8'd0, 0);
    do_req("add_m128",   2'd0, 8'h80, 8'd5, 0);
    do_req("sub_100",    2'd1, 8'd100, 8'hE5, 0);
    do_req("hold5",      2'd3, 8'hF0, 8'd3, 5);

    for (int i = 0; i < 17; i++)
      do_req("b2b", 2'($urandom), rand_operand(), rand_operand(), 0);

    for (int i = 0; i < 20; i++)
      do_req("rand", 2'($urandom), rand_operand(), rand_operand(), int'($urandom_range(0, 2)));

    // reset while a result is waiting in ISSUE
    in_valid  = 1'b1;
    in_op     = 2'd0;
    in_a      = 8'd9;
    in_b      = 8'd4;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset issue valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async drop valid", 32'(out_valid), 32'd0);
    check("async clear tag",  32'(out_tag), 32'd0);
    check("async clear mag",  32'(out_mag_a), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no stale result", 32'(out_valid), 32'd0);
    end
    exp_tag = 0;
    @(posedge clk);
    #1;
    do_req("after_reset", 2'd1, 8'd20, 8'd30, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
